// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage status in, stall/flush/halt controls out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             d_valid;
  logic [4:0]       d_s_1;
  logic [4:0]       d_s_2;
  logic             x_valid;
  logic             x_is_load;
  logic [4:0]       x_tgt_1;
  logic [4:0]       x_tgt_2;
  logic             x_branch_taken;
  logic             m_busy;
  logic             wb_exc;
  logic             halt_req;
  logic             wake;
  logic             clr_count;

  logic             stall;
  logic             bubble_x;
  logic             flush;
  logic             halt;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output d_valid, d_s_1, d_s_2, x_valid, x_is_load, x_tgt_1, x_tgt_2,
           x_branch_taken, m_busy, wb_exc, halt_req, wake, clr_count,
    input  stall, bubble_x, flush, halt, state_o, stall_count
  );

  modport slave (
    input  d_valid, d_s_1, d_s_2, x_valid, x_is_load, x_tgt_1, x_tgt_2,
           x_branch_taken, m_busy, wb_exc, halt_req, wake, clr_count,
    output stall, bubble_x, flush, halt, state_o, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipe with a saturating stall-cycle counter.
//   state    | meaning
//   RUN      | normal issue; load-use and memory-busy stalls, redirect entry
//   REDIRECT | flush held for FLUSH_CYCLES cycles after a branch/exception
//   HALTED   | pipe frozen until wake (or an exception redirects)
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    REDIRECT = 3'd1,
    HALTED   = 3'd2
  } state_t;

  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q;
  logic             stall_c, bubble_c, flush_c, halt_c;
  logic             hit, load_use, redirect;

  assign hit = ((bus.x_tgt_1 != 5'd0) &&
                ((bus.x_tgt_1 == bus.d_s_1) || (bus.x_tgt_1 == bus.d_s_2))) ||
               ((bus.x_tgt_2 != 5'd0) &&
                ((bus.x_tgt_2 == bus.d_s_1) || (bus.x_tgt_2 == bus.d_s_2)));

  assign load_use = bus.d_valid && bus.x_valid && bus.x_is_load && hit;
  assign redirect = bus.wb_exc || bus.x_branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    halt_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = REDIRECT;
            cnt_d   = RELOAD;
          end
        end else if (bus.halt_req) begin
          state_d = HALTED;
        end else if (bus.m_busy) begin
          stall_c = 1'b1;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      REDIRECT: begin
        flush_c = 1'b1;
        if (redirect) begin
          cnt_d = RELOAD;
        end else if (bus.m_busy) begin
          stall_c = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end
      end
      HALTED: begin
        // An exception while parked behaves exactly like one taken from RUN.
        if (bus.wb_exc) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = REDIRECT;
            cnt_d   = RELOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          halt_c  = 1'b1;
          stall_c = 1'b1;
          if (bus.wake) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (bus.clr_count) begin
      count_q <= '0;
    end else if (stall_c && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Gate with rst_n so controls drop the instant reset asserts, even with busy inputs.
  assign bus.stall       = rst_n & stall_c;
  assign bus.bubble_x    = rst_n & bubble_c;
  assign bus.flush       = rst_n & flush_c;
  assign bus.halt        = rst_n & halt_c;
  assign bus.state_o     = state_q;
  assign bus.stall_count = count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations from a cycle model, directed plus random stimulus.
module tb_hazard_ctrl;

  localparam int FC    = 2;
  localparam int CW    = 4;
  localparam int SCMAX = (1 << CW) - 1;

  typedef struct {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       halt;
    logic [2:0] state;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  exp_t sb[$];

  int m_state = 0, n_state = 0;
  int m_cnt = 0, n_cnt = 0;
  int m_sc = 0, n_sc = 0;

  logic last_stall, last_bubble, last_flush, last_halt;
  logic [2:0] last_state;
  logic [CW-1:0] last_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    bus.d_valid = 0; bus.d_s_1 = 0; bus.d_s_2 = 0;
    bus.x_valid = 0; bus.x_is_load = 0; bus.x_tgt_1 = 0; bus.x_tgt_2 = 0;
    bus.x_branch_taken = 0; bus.m_busy = 0; bus.wb_exc = 0;
    bus.halt_req = 0; bus.wake = 0; bus.clr_count = 0;
  endtask

  task automatic begin_cyc();
    @(negedge clk);
    clear_inputs();
  endtask

  // Reference behaviour computed from the stimulus currently on the bus.
  task automatic model_eval(output exp_t e);
    bit hit1, hit2, lu, exc, br;
    hit1 = (bus.x_tgt_1 != 0) && (bus.x_tgt_1 == bus.d_s_1 || bus.x_tgt_1 == bus.d_s_2);
    hit2 = (bus.x_tgt_2 != 0) && (bus.x_tgt_2 == bus.d_s_1 || bus.x_tgt_2 == bus.d_s_2);
    lu  = bus.d_valid && bus.x_valid && bus.x_is_load && (hit1 || hit2);
    exc = bus.wb_exc;
    br  = bus.x_branch_taken;
    e.stall = 0; e.bubble = 0; e.flush = 0; e.halt = 0;
    e.state = 3'(m_state);
    e.cnt   = CW'(m_sc);
    n_state = m_state;
    n_cnt   = m_cnt;
    if (m_state == 0) begin
      if (exc || br) begin
        e.flush = 1;
        if (FC > 1) begin n_state = 1; n_cnt = FC - 1; end
      end else if (bus.halt_req) n_state = 2;
      else if (bus.m_busy) e.stall = 1;
      else if (lu) begin e.stall = 1; e.bubble = 1; end
    end else if (m_state == 1) begin
      e.flush = 1;
      if (exc || br) n_cnt = FC - 1;
      else if (bus.m_busy) e.stall = 1;
      else begin
        n_cnt = m_cnt - 1;
        if (n_cnt == 0) n_state = 0;
      end
    end else begin
      if (exc) begin
        e.flush = 1;
        n_state = (FC > 1) ? 1 : 0;
        n_cnt   = FC - 1;
      end else begin
        e.halt = 1; e.stall = 1;
        if (bus.wake) n_state = 0;
      end
    end
    if (bus.clr_count) n_sc = 0;
    else if (e.stall && m_sc < SCMAX) n_sc = m_sc + 1;
    else n_sc = m_sc;
  endtask

  task automatic tick();
    exp_t e_push, e_pop;
    model_eval(e_push);
    sb.push_back(e_push);
    #2;
    e_pop = sb.pop_front();
    chk("stall",    bus.stall,       e_pop.stall);
    chk("bubble_x", bus.bubble_x,    e_pop.bubble);
    chk("flush",    bus.flush,       e_pop.flush);
    chk("halt",     bus.halt,        e_pop.halt);
    chk("state_o",  bus.state_o,     e_pop.state);
    chk("count",    bus.stall_count, e_pop.cnt);
    last_stall = bus.stall; last_bubble = bus.bubble_x; last_flush = bus.flush;
    last_halt = bus.halt; last_state = bus.state_o; last_cnt = bus.stall_count;
    @(posedge clk);
    m_state = n_state; m_cnt = n_cnt; m_sc = n_sc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, hl;
    clear_inputs();
    bus.m_busy = 1; bus.x_branch_taken = 1;
    #3;
    chk("rst_stall", bus.stall, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_halt",  bus.halt, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_count", bus.stall_count, 0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    @(posedge clk);

    // load-use: tgt_1 vs s_2, zero register, tgt_2 vs s_1
    begin_cyc();
    bus.x_valid = 1; bus.x_is_load = 1; bus.x_tgt_1 = 5; bus.d_valid = 1; bus.d_s_2 = 5;
    tick();
    chk("lu1_bubble", last_bubble, 1);
    begin_cyc(); tick();
    chk("lu1_after", last_stall, 0);
    begin_cyc();
    bus.x_valid = 1; bus.x_is_load = 1; bus.x_tgt_1 = 0; bus.d_valid = 1; bus.d_s_1 = 0;
    tick();
    chk("lu_zero", last_stall, 0);
    begin_cyc();
    bus.x_valid = 1; bus.x_is_load = 1; bus.x_tgt_2 = 7; bus.d_valid = 1; bus.d_s_1 = 7;
    tick();
    chk("lu_tgt2", last_stall, 1);
    begin_cyc();
    bus.x_valid = 1; bus.x_is_load = 0; bus.x_tgt_1 = 3; bus.d_valid = 1; bus.d_s_1 = 3;
    tick();
    chk("lu_noload", last_stall, 0);

    // redirect with m_busy stretching it
    fl = 0;
    begin_cyc(); bus.x_branch_taken = 1; tick(); fl += int'(last_flush);
    chk("br_state0", last_state, 0);
    for (int i = 0; i < 3; i++) begin
      begin_cyc(); bus.m_busy = 1; tick(); fl += int'(last_flush);
      chk("br_busy_stall", last_stall, 1);
    end
    for (int i = 0; i < 3; i++) begin
      begin_cyc(); tick(); fl += int'(last_flush);
    end
    chk("br_flush_len", fl, 5);
    chk("br_back_run", last_state, 0);

    // back-to-back redirects
    fl = 0;
    begin_cyc(); bus.wb_exc = 1; tick(); fl += int'(last_flush);
    begin_cyc(); bus.x_branch_taken = 1; tick(); fl += int'(last_flush);
    for (int i = 0; i < 3; i++) begin
      begin_cyc(); tick(); fl += int'(last_flush);
    end
    chk("b2b_flush_len", fl, 3);
    begin_cyc(); bus.wb_exc = 1; bus.halt_req = 1; tick();
    chk("exc_halt_flush", last_flush, 1);
    begin_cyc(); tick();
    chk("exc_halt_state", last_state, 1);
    begin_cyc(); tick();

    // halt / wake
    begin_cyc(); bus.halt_req = 1; tick();
    chk("halt_req_cycle", last_halt, 0);
    hl = 0;
    for (int i = 0; i < 10; i++) begin
      begin_cyc(); bus.m_busy = (i == 4); tick(); hl += int'(last_halt);
    end
    chk("halt_held", hl, 10);
    begin_cyc(); bus.wake = 1; tick();
    chk("wake_cycle_halt", last_halt, 1);
    begin_cyc(); tick();
    chk("woke_halt", last_halt, 0);
    chk("woke_state", last_state, 0);
    begin_cyc(); bus.halt_req = 1; tick();
    begin_cyc(); bus.wb_exc = 1; bus.wake = 1; tick();
    chk("halted_exc_flush", last_flush, 1);
    begin_cyc(); tick();
    chk("halted_exc_state", last_state, 1);
    begin_cyc(); tick();

    // counter saturation and clear
    begin_cyc(); bus.clr_count = 1; tick();
    for (int i = 0; i < 20; i++) begin
      begin_cyc(); bus.m_busy = 1; tick();
    end
    begin_cyc(); bus.m_busy = 1; bus.clr_count = 1; tick();
    chk("cnt_sat", last_cnt, 15);
    begin_cyc(); bus.m_busy = 1; tick();
    chk("cnt_clr", last_cnt, 0);
    begin_cyc(); bus.m_busy = 1; tick();
    chk("cnt_inc", last_cnt, 1);

    // async reset mid-REDIRECT
    begin_cyc(); bus.x_branch_taken = 1; tick();
    @(negedge clk);
    clear_inputs();
    bus.m_busy = 1;
    #1;
    chk("pre_rst_flush", bus.flush, 1);
    rst_n = 0;
    #1;
    chk("arst_flush", bus.flush, 0);
    chk("arst_stall", bus.stall, 0);
    chk("arst_halt",  bus.halt, 0);
    chk("arst_state", bus.state_o, 0);
    m_state = 0; m_cnt = 0; m_sc = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    @(posedge clk);
    begin_cyc(); tick();
    chk("post_rst_state", last_state, 0);
    chk("post_rst_count", last_cnt, 0);
    chk("post_rst_flush", last_flush, 0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      begin_cyc();
      bus.d_valid        = $urandom_range(0, 1);
      bus.d_s_1          = 5'($urandom_range(0, 5));
      bus.d_s_2          = 5'($urandom_range(0, 5));
      bus.x_valid        = $urandom_range(0, 1);
      bus.x_is_load      = $urandom_range(0, 1);
      bus.x_tgt_1        = 5'($urandom_range(0, 5));
      bus.x_tgt_2        = 5'($urandom_range(0, 5));
      bus.x_branch_taken = ($urandom_range(0, 9) == 0);
      bus.m_busy         = ($urandom_range(0, 3) == 0);
      bus.wb_exc         = ($urandom_range(0, 15) == 0);
      bus.halt_req       = ($urandom_range(0, 15) == 0);
      bus.wake           = ($urandom_range(0, 5) == 0);
      bus.clr_count      = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage pipe.
- Resolves load-use hazards between decode and execute, freezes the pipe while memory is busy, and squashes wrong-path instructions after taken branches and writeback exceptions.
- Parks the core in a halted state until a wake event arrives.
- Drives the stall, flush and halt inputs of decode and the neighbouring stages. Keeps a saturating stall-cycle performance counter.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles flush stays high per redirect (1..7).
CNT_W, 16, width of stall_count.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  decode slot holds a real instruction (not a bubble)
d_s_1  in  5  decode source register 1
d_s_2  in  5  decode source register 2
x_valid  in  1  execute slot holds a real instruction
x_is_load  in  1  execute instruction is a load
x_tgt_1  in  5  execute primary target (0 = none)
x_tgt_2  in  5  execute increment-writeback target (0 = none)
x_branch_taken  in  1  execute resolved a taken branch/jump this cycle
m_busy  in  1  memory stage waiting on the memory port
wb_exc  in  1  exception/interrupt/syscall committing at writeback
halt_req  in  1  halt instruction committing at writeback
wake  in  1  pending unmasked interrupt (OR of interrupt lines)
clr_count  in  1  synchronous clear of stall_count
stall  out  1  hold fetch and decode registers
bubble_x  out  1  load bubble into execute
flush  out  1  squash fetch/decode contents
halt  out  1  freeze entire pipe
state_o  out  3  current FSM state (debug)
stall_count  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- States: RUN=0, REDIRECT=1, HALTED=2. Encodings 3..7 are unused; if reached, go to RUN on the next edge.
- Reset (rst_n=0, async):
  - state=RUN, flush counter=0, stall_count=0.
  - All outputs 0 while rst_n is low.
  - Reset mid-REDIRECT or mid-HALTED returns to RUN with no residual flush.
- load_use (combinational): d_valid & x_valid & x_is_load & hit, where hit = (x_tgt_1≠0 & (x_tgt_1==d_s_1 | x_tgt_1==d_s_2)) | (x_tgt_2≠0 & (x_tgt_2==d_s_1 | x_tgt_2==d_s_2)).
- Outputs are combinational from state and inputs; no added latency.
- Event priority: wb_exc > x_branch_taken > halt_req > m_busy > load_use.
- RUN:
  - wb_exc or x_branch_taken: flush=1 this cycle. If FLUSH_CYCLES>1, go to REDIRECT with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else halt_req: go to HALTED; halt=1 from the next cycle.
  - Else m_busy: stall=1, bubble_x=0 (whole front end holds).
  - Else load_use: stall=1, bubble_x=1 for exactly this cycle. The condition clears itself next cycle because the load advances.
- REDIRECT:
  - flush=1 every cycle; load_use is ignored.
  - m_busy: stall=1 and the counter freezes.
  - Otherwise the counter decrements; at 1→0, go to RUN (flush low on the following cycle).
  - New wb_exc or x_branch_taken: counter reloads to FLUSH_CYCLES-1 and flush stays high.
  - halt_req is ignored here.
- HALTED:
  - halt=1, stall=1, all other outputs 0.
  - wake: go to RUN, halt=0 next cycle.
  - wb_exc: go to REDIRECT with flush=1 that cycle, exactly as in RUN; this takes priority over wake.
- stall_count:
  - +1 on each rising edge where stall=1.
  - Saturates at 2^CNT_W-1.
  - clr_count takes priority over increment (value becomes 0).
- halt_req in the same cycle as wb_exc: the exception wins and HALTED is not entered.

Test Plan:
1. Load-use: x_valid=1, x_is_load=1, x_tgt_1=5, d_valid=1, d_s_2=5 for one cycle -> stall=1, bubble_x=1 in that cycle only. Repeat with x_tgt_1=0, d_s_1=0 -> stall=0. Repeat with x_tgt_2=7, d_s_1=7 -> stall=1.
2. Redirect, FLUSH_CYCLES=2: pulse x_branch_taken -> flush=1 for 2 cycles, state_o 0→1→0. Raise m_busy during the second flush cycle for 3 cycles -> flush stays high for 3 extra cycles and stall=1.
3. Back-to-back redirects: wb_exc, then x_branch_taken one cycle later -> flush continuous for 3 cycles. wb_exc and halt_req together -> no HALTED, flush=1.
4. Halt/wake: halt_req=1 -> halt=1 from the next cycle and held for 10 idle cycles. wake=1 -> halt=0 one cycle later, state_o=0. Separately, wb_exc while halted -> flush=1 and state_o=1.
5. Counter, CNT_W=4: hold m_busy for 20 cycles -> stall_count=15 (saturated). clr_count with m_busy=1 -> 0, then increments.
6. Async reset: assert rst_n=0 mid-REDIRECT between clock edges -> flush, stall, halt drop immediately. After release, state_o=0 and stall_count=0.
